// File: rtl/apb_master_arbiter_pkg.sv
// Shared types and constants for the round-robin APB master.
package apb_rtl_pack;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic P_WRITE = 1'b1;
  localparam logic P_READ  = 1'b0;

  localparam int DEF_TIMER_OUT = 10;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin one-hot picker: searches upward from the pointer, wraps, and
// moves the pointer past the winner whenever a grant is taken.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               idx;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IDX_W'(idx);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin accept, SETUP/ACCESS
// sequencing, per-requester one-cycle response pulse and wait-state timeout.
module apb_master_arbiter
  import apb_rtl_pack::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMER_OUT  = DEF_TIMER_OUT
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMER_OUT + 1);

  apb_state_e              state;
  logic [CNT_W-1:0]        wait_cnt;
  logic [IDX_W-1:0]        cur_idx;

  logic                    completion;
  logic                    timeout;
  logic                    accept_en;
  logic                    accept;
  logic [NUM_REQ-1:0]      arb_req;
  logic [NUM_REQ-1:0]      grant;
  logic [IDX_W-1:0]        grant_idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    sel_write;

  assign completion = (state == ACCESS) && PREADY;
  assign timeout    = (state == ACCESS) && !PREADY && (wait_cnt == CNT_W'(TIMER_OUT - 1));
  assign accept_en  = (state == IDLE) || completion;

  // A requester whose response is on the wire this cycle is not offered a new slot.
  assign arb_req    = req_valid & ~rsp_valid;
  assign req_ready  = grant;
  assign accept     = |grant;

  assign PSEL       = (state != IDLE);
  assign PENABLE    = (state == ACCESS);

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (PCLK),
    .rst       (PRESET),
    .req       (arb_req),
    .enable    (accept_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_write = req_write[i];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cur_idx   <= '0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;

      case (state)
        IDLE:   ;
        SETUP:  state <= ACCESS;
        ACCESS: begin
          if (PREADY || timeout) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // An accept overrides the IDLE return above, giving back-to-back SETUP.
      if (accept) begin
        state    <= SETUP;
        wait_cnt <= '0;
        cur_idx  <= grant_idx;
        PADDR    <= sel_addr;
        PWRITE   <= sel_write;
        PWDATA   <= (sel_write == P_WRITE) ? sel_wdata : '0;
      end

      if (completion) begin
        rsp_valid[cur_idx] <= 1'b1;
        rsp_rdata          <= (PWRITE == P_READ) ? PRDATA : '0;
        rsp_err            <= PSLVERR;
      end else if (timeout) begin
        rsp_valid[cur_idx] <= 1'b1;
        rsp_rdata          <= '0;
        rsp_err            <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: cycle table for single transfers,
// hand sequences for back-to-back, timeout and mid-transfer reset.
module tb_apb_master_arbiter;

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0000_0020;
  localparam logic [31:0] W0 = 32'hA5A5_A5A5;
  localparam logic [31:0] W1 = 32'h0BAD_F00D;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks   = 0;
  int failures = 0;

  apb_master_arbiter #(
    .NUM_REQ    (2),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMER_OUT  (10)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [1:0]  rv;
    logic [1:0]  rw;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        psel;
    logic        pen;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [1:0]  ready;
    logic [1:0]  rsp;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [19];

  logic [1:0]  b2b_ready [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  logic        b2b_psel  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        b2b_pen   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0]  b2b_rsp   [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
  logic [31:0] b2b_paddr [8] = '{32'h0, A0, A0, A1, A1, A0, A0, A1};

  function automatic vec_t mk(
    input logic [1:0] rv, rw, input logic pr, se, input logic [31:0] rd,
    input logic ps, pe, pw, input logic [31:0] pa, pd,
    input logic [1:0] rdy, rsp, input logic er, input logic [31:0] rdat);
    vec_t v;
    v.rv = rv; v.rw = rw; v.pready = pr; v.pslverr = se; v.prdata = rd;
    v.psel = ps; v.pen = pe; v.pwrite = pw; v.paddr = pa; v.pwdata = pd;
    v.ready = rdy; v.rsp = rsp; v.err = er; v.rdata = rdat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    PRESET    = 1'b1;
    req_valid = 2'b00;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    tick();
    tick();
    PRESET    = 1'b0;
  endtask

  task automatic drain(input string name);
    logic done;
    done      = 1'b0;
    req_valid = 2'b00;
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;
    for (int n = 0; n < 12; n++) begin
      #1;
      if (!PSEL && rsp_valid == 2'b00) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check(name, done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the end of the test");
    $fatal(1, "bench timed out");
  end

  initial begin
    req_write = 2'b00;
    req_addr  = {A1, A0};
    req_wdata = {W1, W0};
    do_reset();

    check("reset_psel",    PSEL,      1'b0);
    check("reset_penable", PENABLE,   1'b0);
    check("reset_pwrite",  PWRITE,    1'b0);
    check("reset_paddr",   PADDR,     32'h0);
    check("reset_pwdata",  PWDATA,    32'h0);
    check("reset_rsp",     rsp_valid, 2'b00);
    check("reset_rdata",   rsp_rdata, 32'h0);
    check("reset_err",     rsp_err,   1'b0);

    //               rv     rw     rdy se prdata          ps pe pw paddr pwdata  ready  rsp    er rdata
    tbl[0]  = mk(2'b01, 2'b01, 1, 0, 32'h0,          0, 0, 0, 32'h0, 32'h0, 2'b01, 2'b00, 0, 32'h0);
    tbl[1]  = mk(2'b00, 2'b01, 1, 0, 32'h0,          1, 0, 1, A0,    W0,    2'b00, 2'b00, 0, 32'h0);
    tbl[2]  = mk(2'b00, 2'b01, 1, 0, 32'h0,          1, 1, 1, A0,    W0,    2'b00, 2'b00, 0, 32'h0);
    tbl[3]  = mk(2'b00, 2'b00, 0, 0, 32'h0,          0, 0, 1, A0,    W0,    2'b00, 2'b01, 0, 32'h0);
    tbl[4]  = mk(2'b10, 2'b00, 0, 0, 32'h0,          0, 0, 1, A0,    W0,    2'b10, 2'b00, 0, 32'h0);
    tbl[5]  = mk(2'b00, 2'b00, 0, 0, 32'h0,          1, 0, 0, A1,    32'h0, 2'b00, 2'b00, 0, 32'h0);
    tbl[6]  = mk(2'b00, 2'b00, 0, 1, 32'hDEAD,       1, 1, 0, A1,    32'h0, 2'b00, 2'b00, 0, 32'h0);
    tbl[7]  = mk(2'b00, 2'b00, 0, 0, 32'h0,          1, 1, 0, A1,    32'h0, 2'b00, 2'b00, 0, 32'h0);
    tbl[8]  = mk(2'b00, 2'b00, 0, 1, 32'hBEEF,       1, 1, 0, A1,    32'h0, 2'b00, 2'b00, 0, 32'h0);
    tbl[9]  = mk(2'b00, 2'b00, 1, 0, 32'h1234,       1, 1, 0, A1,    32'h0, 2'b00, 2'b00, 0, 32'h0);
    tbl[10] = mk(2'b00, 2'b00, 0, 0, 32'hFFFF,       0, 0, 0, A1,    32'h0, 2'b00, 2'b10, 0, 32'h1234);
    tbl[11] = mk(2'b01, 2'b01, 1, 0, 32'h0,          0, 0, 0, A1,    32'h0, 2'b01, 2'b00, 0, 32'h0);
    tbl[12] = mk(2'b00, 2'b01, 0, 0, 32'h0,          1, 0, 1, A0,    W0,    2'b00, 2'b00, 0, 32'h0);
    tbl[13] = mk(2'b00, 2'b01, 1, 1, 32'h7777,       1, 1, 1, A0,    W0,    2'b00, 2'b00, 0, 32'h0);
    tbl[14] = mk(2'b01, 2'b01, 0, 0, 32'h0,          0, 0, 1, A0,    W0,    2'b00, 2'b01, 1, 32'h0);
    tbl[15] = mk(2'b01, 2'b01, 0, 0, 32'h0,          0, 0, 1, A0,    W0,    2'b01, 2'b00, 0, 32'h0);
    tbl[16] = mk(2'b00, 2'b01, 0, 0, 32'h0,          1, 0, 1, A0,    W0,    2'b00, 2'b00, 0, 32'h0);
    tbl[17] = mk(2'b00, 2'b01, 1, 0, 32'h0,          1, 1, 1, A0,    W0,    2'b00, 2'b00, 0, 32'h0);
    tbl[18] = mk(2'b00, 2'b00, 0, 0, 32'h0,          0, 0, 1, A0,    W0,    2'b00, 2'b01, 0, 32'h0);

    for (int i = 0; i < 19; i++) begin
      req_valid = tbl[i].rv;
      req_write = tbl[i].rw;
      PREADY    = tbl[i].pready;
      PSLVERR   = tbl[i].pslverr;
      PRDATA    = tbl[i].prdata;
      #1;
      check($sformatf("row%0d_psel", i),    PSEL,      tbl[i].psel);
      check($sformatf("row%0d_penable", i), PENABLE,   tbl[i].pen);
      check($sformatf("row%0d_pwrite", i),  PWRITE,    tbl[i].pwrite);
      check($sformatf("row%0d_paddr", i),   PADDR,     tbl[i].paddr);
      check($sformatf("row%0d_pwdata", i),  PWDATA,    tbl[i].pwdata);
      check($sformatf("row%0d_ready", i),   req_ready, tbl[i].ready);
      check($sformatf("row%0d_rsp", i),     rsp_valid, tbl[i].rsp);
      if (tbl[i].rsp != 2'b00) begin
        check($sformatf("row%0d_err", i),   rsp_err,   tbl[i].err);
        check($sformatf("row%0d_rdata", i), rsp_rdata, tbl[i].rdata);
      end
      tick();
    end

    // Both requesters continuously valid, zero-wait slave: alternating grants, no IDLE gap.
    do_reset();
    req_write = 2'b01;
    req_valid = 2'b11;
    PREADY    = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("b2b%0d_ready", c),   req_ready, b2b_ready[c]);
      check($sformatf("b2b%0d_psel", c),    PSEL,      b2b_psel[c]);
      check($sformatf("b2b%0d_penable", c), PENABLE,   b2b_pen[c]);
      check($sformatf("b2b%0d_rsp", c),     rsp_valid, b2b_rsp[c]);
      check($sformatf("b2b%0d_paddr", c),   PADDR,     b2b_paddr[c]);
      tick();
    end
    drain("b2b_drain");

    // Slave never ready: exactly TIMER_OUT ACCESS cycles, then abort with error.
    do_reset();
    req_write = 2'b00;
    req_valid = 2'b01;
    PREADY    = 1'b0;
    PRDATA    = 32'hCAFE;
    #1;
    check("to_accept_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    check("to_setup_penable", PENABLE, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) req_valid = 2'b10;
      #1;
      check($sformatf("to_access%0d_psel", i),    PSEL,    1'b1);
      check($sformatf("to_access%0d_penable", i), PENABLE, 1'b1);
      if (i == 9) check("to_abort_no_accept", req_ready, 2'b00);
      tick();
    end
    #1;
    check("to_after_psel",    PSEL,      1'b0);
    check("to_after_penable", PENABLE,   1'b0);
    check("to_after_rsp",     rsp_valid, 2'b01);
    check("to_after_err",     rsp_err,   1'b1);
    check("to_after_rdata",   rsp_rdata, 32'h0);
    check("to_after_ready",   req_ready, 2'b10);
    tick();
    drain("to_drain");

    // Reset in the middle of ACCESS drops the transfer and rewinds the pointer.
    do_reset();
    req_write = 2'b01;
    req_valid = 2'b01;
    #1;
    check("rst_first_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    PREADY = 1'b0;
    PRESET = 1'b1;
    #1;
    check("rst_in_access", PENABLE, 1'b1);
    tick();
    PRESET    = 1'b0;
    req_valid = 2'b11;
    #1;
    check("rst_psel",    PSEL,      1'b0);
    check("rst_penable", PENABLE,   1'b0);
    check("rst_pwrite",  PWRITE,    1'b0);
    check("rst_paddr",   PADDR,     32'h0);
    check("rst_pwdata",  PWDATA,    32'h0);
    check("rst_rsp",     rsp_valid, 2'b00);
    check("rst_rdata",   rsp_rdata, 32'h0);
    check("rst_err",     rsp_err,   1'b0);
    check("rst_ready",   req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    check("rst_next_rsp",   rsp_valid, 2'b00);
    check("rst_next_paddr", PADDR,     A0);
    tick();
    drain("rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
